// File: rtl/neuron_packet_sequencer.sv
// Neuron packet sequencer: time-multiplexes one neuron block across
// NUM_NEURONS neurons, keeps their potentials, and emits fired spikes.
module neuron_packet_sequencer #(
  parameter int NUM_NEURONS = 256,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pkt_valid_i,
  output logic             pkt_ready_o,
  input  logic [IDX_W-1:0] pkt_neuron_i,
  input  logic [1:0]       pkt_wsel_i,
  input  logic             pkt_conn_i,
  input  logic             pkt_first_i,
  input  logic             pkt_last_i,
  output logic [7:0]       nb_voltage_o,
  output logic [1:0]       nb_wsel_o,
  output logic             nb_enable_o,
  output logic             nb_new_image_o,
  output logic             nb_last_image_o,
  input  logic [7:0]       nb_potential_i,
  input  logic             nb_spike_i,
  output logic             spk_valid_o,
  input  logic             spk_ready_i,
  output logic [IDX_W-1:0] spk_neuron_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACCUM, S_FIRE, S_EMIT} state_e;

  // Beat currently being presented to the neuron block; have=0 marks an
  // ACCUM cycle with nothing to apply (no beat fetched, or a stray one).
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             conn;
    logic [1:0]       wsel;
    logic             last;
    logic             have;
  } beat_t;

  state_e     r_state, w_state_d;
  beat_t      r_beat, w_beat_d;
  logic [7:0] r_store [NUM_NEURONS];

  logic       r_ready, w_ready_d;
  logic [7:0] r_volt, w_volt_d;
  logic [1:0] r_wsel, w_wsel_d;
  logic       r_en, w_en_d;
  logic       r_new, w_new_d;
  logic       r_last, w_last_d;
  logic       w_acc, w_apply;

  // Next state and next beat: capture on first beat, drop strays, fire on last.
  always_comb begin
    w_state_d = r_state;
    w_beat_d  = r_beat;
    w_acc     = pkt_valid_i && r_ready;
    case (r_state)
      S_IDLE: begin
        if (w_acc && pkt_first_i) begin
          w_beat_d.idx  = pkt_neuron_i;
          w_beat_d.conn = pkt_conn_i;
          w_beat_d.wsel = pkt_wsel_i;
          w_beat_d.last = pkt_last_i;
          w_beat_d.have = 1'b1;
          w_state_d     = S_LOAD;
        end
      end
      // captured first beat is replayed in ACCUM unless it already closes the image
      S_LOAD: w_state_d = r_beat.last ? S_FIRE : S_ACCUM;
      S_ACCUM: begin
        if (r_beat.have && r_beat.last) begin
          w_state_d = S_FIRE;
        end else if (w_acc && (pkt_neuron_i == r_beat.idx)) begin
          w_beat_d.conn = pkt_conn_i;
          w_beat_d.wsel = pkt_wsel_i;
          w_beat_d.last = pkt_last_i;
          w_beat_d.have = 1'b1;
        end else begin
          w_beat_d.have = 1'b0;
        end
      end
      S_FIRE: w_state_d = nb_spike_i ? S_EMIT : S_IDLE;
      S_EMIT: if (spk_ready_i) w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  // Registered-output values decoded from the state and beat being entered.
  always_comb begin
    w_apply   = (w_state_d == S_ACCUM) && w_beat_d.have;
    w_new_d   = (w_state_d == S_LOAD);
    w_last_d  = (w_state_d == S_FIRE);
    w_en_d    = (w_apply && w_beat_d.conn) || w_last_d;
    w_wsel_d  = (w_apply || w_last_d) ? w_beat_d.wsel : 2'b00;
    w_volt_d  = (w_state_d inside {S_LOAD, S_ACCUM, S_FIRE}) ? r_store[w_beat_d.idx] : 8'h00;
    w_ready_d = (w_state_d == S_IDLE) ||
                ((w_state_d == S_ACCUM) && !(w_beat_d.have && w_beat_d.last));
  end

  // State, beat and all outgoing strobes; reset aborts and silences everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_ready <= 1'b0;
      r_volt  <= '0;
      r_wsel  <= '0;
      r_en    <= 1'b0;
      r_new   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_beat  <= w_beat_d;
      r_ready <= w_ready_d;
      r_volt  <= w_volt_d;
      r_wsel  <= w_wsel_d;
      r_en    <= w_en_d;
      r_new   <= w_new_d;
      r_last  <= w_last_d;
    end
  end

  // Potential store: FIRE writes back the block's result for the current neuron.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_store[i] <= '0;
    end else if (r_state == S_FIRE) begin
      r_store[r_beat.idx] <= nb_potential_i;
    end
  end

  assign pkt_ready_o     = r_ready;
  assign nb_voltage_o    = r_volt;
  assign nb_wsel_o       = r_wsel;
  assign nb_enable_o     = r_en;
  assign nb_new_image_o  = r_new;
  assign nb_last_image_o = r_last;
  assign spk_valid_o     = (r_state == S_EMIT);
  assign spk_neuron_o    = spk_valid_o ? r_beat.idx : '0;
  assign busy_o          = (r_state != S_IDLE);

endmodule

// File: doc/neuron_packet_sequencer.md
Name: neuron_packet_sequencer

Overview:
- Initiator side of the neuron-block integration interface.
- Accepts a stream of per-neuron axon-spike beats over valid/ready and time-multiplexes one combinational neuron block across NUM_NEURONS neurons.
- Drives the block's load/enable/last/weight-select strobes and writes the returned potential back into a per-neuron potential store.
- Emits each fired spike as an output event over valid/ready toward the spike router.

Parameters:
- NUM_NEURONS, 256, number of neurons sharing the neuron block; must be a power of two, max 256.
- IDX_W, 8, neuron index width; equals log2(NUM_NEURONS).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- pkt_valid_i  in  1  axon beat valid.
- pkt_ready_o  out  1  sequencer accepts the beat when valid and ready are both high.
- pkt_neuron_i  in  IDX_W  target neuron index.
- pkt_wsel_i  in  2  axon weight type.
- pkt_conn_i  in  1  synapse connected, so the weight is applied.
- pkt_first_i  in  1  first beat of the image for this neuron.
- pkt_last_i  in  1  last beat of the image for this neuron.
- nb_voltage_o  out  8  potential presented to the neuron block.
- nb_wsel_o  out  2  weight select to the neuron block.
- nb_enable_o  out  1  neuron block enable.
- nb_new_image_o  out  1  load strobe.
- nb_last_image_o  out  1  finalize strobe.
- nb_potential_i  in  8  new potential returned by the neuron block (signed).
- nb_spike_i  in  1  spike returned by the neuron block.
- spk_valid_o  out  1  spike event valid.
- spk_ready_i  in  1  downstream accepts the spike event.
- spk_neuron_o  out  IDX_W  index of the neuron that fired.
- busy_o  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM goes to IDLE.
  - Every potential-store entry is cleared to 0.
  - Reset asserted mid-operation aborts immediately. A pending spike event is dropped and no write-back occurs.
- Potential store: NUM_NEURONS x 8-bit registers, indexed by the captured neuron index cur_idx.
- FSM states:
  - IDLE: pkt_ready_o=1.
    - A beat with first=1 captures cur_idx and its fields, then goes to LOAD.
    - A beat with first=0 in IDLE is consumed and dropped.
  - LOAD, 1 cycle: nb_new_image_o=1, nb_enable_o=0, nb_voltage_o=store[cur_idx].
    - The captured first beat is then replayed as an ACCUM beat. If it also had last=1, it goes straight to FIRE.
  - ACCUM: one cycle per beat, then pkt_ready_o=1 to fetch the next beat.
    - nb_enable_o=pkt_conn of the beat, nb_wsel_o=pkt_wsel, nb_last_image_o=0.
    - A beat with last=1 goes to FIRE.
    - A beat whose neuron index differs from cur_idx is consumed and ignored. It does not terminate the image.
  - FIRE, 1 cycle: nb_enable_o=1, nb_last_image_o=1, nb_wsel_o=weight of the last beat.
    - If the last beat has conn=0, nb_wsel_o still carries its wsel.
    - nb_potential_i and nb_spike_i are sampled at the end of the cycle.
    - store[cur_idx] <= nb_potential_i.
    - If the sampled spike is 1, go to EMIT. Otherwise go to IDLE.
  - EMIT: spk_valid_o=1, spk_neuron_o=cur_idx, pkt_ready_o=0.
    - Holds until spk_ready_i=1, then goes to IDLE on the next cycle.
    - spk_neuron_o is stable while valid is high.
- Strobe rules:
  - nb_new_image_o and nb_last_image_o are never high together.
  - All nb_* outputs are registered. They are 0 in IDLE and EMIT.
- Backpressure:
  - pkt_ready_o is 0 in LOAD, FIRE and EMIT, so no beat is lost.
  - In ACCUM, ready is high only in the fetch sub-cycle.
- Throughput: one image of K beats takes K+2 cycles, plus EMIT stall cycles.
- Write-back ordering: store[cur_idx] updates before the next first-beat read. A back-to-back image to the same neuron sees the new value.

Test Plan:
- Single image to neuron 5, beats {first,conn,wsel=1},{conn,wsel=2},{last,conn=0}:
  - Required: nb_new_image_o pulses once with voltage 0.
  - nb_enable_o pattern is 1,1,0, then FIRE=1.
  - Model returns potential 40 and spike 0, so store[5]=40 and spk_valid_o stays 0.
- Fire with backpressure:
  - Model returns spike=1 and potential=pos_reset 0 for neuron 200.
  - Hold spk_ready_i=0 for 4 cycles.
  - Required: spk_valid_o=1 with spk_neuron_o=200 stable throughout, and pkt_ready_o=0 throughout.
  - Event is released on the first ready cycle.
- Back-to-back images to neuron 7:
  - Second LOAD drives nb_voltage_o equal to the potential written by the first FIRE.
- Single beat with first=last=1:
  - Required sequence is LOAD then FIRE, 2 cycles, with no ACCUM cycle in between.
- Illegal and stray beats:
  - A beat with first=0 in IDLE is consumed and causes no nb_* activity.
  - A mismatched-index beat in ACCUM is ignored.
- Async reset during ACCUM:
  - Drop rst_ni mid-cycle.
  - Required: outputs are 0 immediately and the store is all 0.
  - After release, the next image to any neuron loads voltage 0.
